mgt_01_mul_arbiter: RTL and testbench

- Shares one iterative radix-4 Booth multiplier between two requesters: port 0 is the integer M-extension unit, port 1 is the FPU mantissa multiply.
- Arbitrates with round-robin priority, loads operands into the multiplier and gates its clock enable for the 17-cycle iteration.
- Captures the result and returns it to the winning requester over a valid/ready response channel.
- Supports flush, which drains an in-flight operation, and includes a latency watchdog.

---
 rtl/mgt_01_mul_arbiter_if.sv | 40 ++++
 rtl/mgt_01_mul_arbiter.sv | 143 ++++++++++++++
 tb/tb_mgt_01_mul_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgt_01_mul_arbiter_if.sv
// Request/response channels of both requesters plus the shared multiplier hookup.
// Slave is the arbiter's view; master is the requester/multiplier side.
interface mgt_01_mul_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [XLEN-1:0] req0_multiplier_i;
    logic [XLEN-1:0] req0_multiplicand_i;
    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [XLEN-1:0] req1_multiplier_i;
    logic [XLEN-1:0] req1_multiplicand_i;
    logic            resp0_valid_o;
    logic            resp0_ready_i;
    logic            resp1_valid_o;
    logic            resp1_ready_i;
    logic [XLEN-1:0] resp_result_o;
    logic            mul_clk_en_o;
    logic [XLEN-1:0] mul_multiplier_o;
    logic [XLEN-1:0] mul_multiplicand_o;
    logic [XLEN-1:0] mul_result_i;
    logic            mul_valid_i;

    modport slave (
        input  req0_valid_i, req0_multiplier_i, req0_multiplicand_i,
        input  req1_valid_i, req1_multiplier_i, req1_multiplicand_i,
        input  resp0_ready_i, resp1_ready_i, mul_result_i, mul_valid_i,
        output req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
        output resp_result_o, mul_clk_en_o, mul_multiplier_o, mul_multiplicand_o
    );

    modport master (
        output req0_valid_i, req0_multiplier_i, req0_multiplicand_i,
        output req1_valid_i, req1_multiplier_i, req1_multiplicand_i,
        output resp0_ready_i, resp1_ready_i, mul_result_i, mul_valid_i,
        input  req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
        input  resp_result_o, mul_clk_en_o, mul_multiplier_o, mul_multiplicand_o
    );
endinterface

// File: rtl/mgt_01_mul_arbiter.sv
// Round-robin arbiter sharing one iterative Booth multiplier between the M-unit (port 0)
// and the FPU mantissa path (port 1), with flush/drain and a latency watchdog.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; accepts only while multiplier is idle
// ST_BUSY  | multiplier iterating for owner_q; capture result on mul_valid
// ST_RESP  | result held on resp_result_o until owner's response handshake
// ST_DRAIN | flushed op still iterating; result discarded on mul_valid
// ST_ERR   | watchdog expired; everything quiet until reset
module mgt_01_mul_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 20
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    mgt_01_mul_arbiter_if.slave bus,
    output logic                err_o
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_DRAIN,
        ST_ERR
    } state_t;

    state_t          state_q;
    logic            ptr_q;
    logic            owner_q;
    logic            err_q;
    logic [XLEN-1:0] result_q;
    logic [WDW-1:0]  wdog_q;

    logic grant;
    logic idle_ok;
    logic rdy0;
    logic rdy1;
    logic accept;
    logic iterating;
    logic resp_hs;

    always_comb begin
        grant = bus.req1_valid_i;
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant = ptr_q;
        end
    end

    // A low mul_valid_i in IDLE means the multiplier is out of step: refuse work.
    assign idle_ok   = (state_q == ST_IDLE) && bus.mul_valid_i && !flush_i;
    assign rdy0      = idle_ok && bus.req0_valid_i && !grant;
    assign rdy1      = idle_ok && bus.req1_valid_i && grant;
    assign accept    = rdy0 || rdy1;
    assign iterating = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
    assign resp_hs   = owner_q ? bus.resp1_ready_i : bus.resp0_ready_i;

    always_comb begin
        bus.mul_multiplier_o   = '0;
        bus.mul_multiplicand_o = '0;
        if (rdy0) begin
            bus.mul_multiplier_o   = bus.req0_multiplier_i;
            bus.mul_multiplicand_o = bus.req0_multiplicand_i;
        end else if (rdy1) begin
            bus.mul_multiplier_o   = bus.req1_multiplier_i;
            bus.mul_multiplicand_o = bus.req1_multiplicand_i;
        end
    end

    // Enable drops in the cycle mul_valid_i returns so the multiplier does not reload.
    assign bus.mul_clk_en_o  = accept || (iterating && !bus.mul_valid_i);
    assign bus.req0_ready_o  = rdy0;
    assign bus.req1_ready_o  = rdy1;
    assign bus.resp0_valid_o = (state_q == ST_RESP) && !owner_q;
    assign bus.resp1_valid_o = (state_q == ST_RESP) && owner_q;
    assign bus.resp_result_o = result_q;
    assign err_o             = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            wdog_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q <= grant;
                        ptr_q   <= ~grant;
                        wdog_q  <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mul_valid_i) begin
                        if (flush_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            result_q <= bus.mul_result_i;
                            state_q  <= ST_RESP;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (flush_i) begin
                        wdog_q  <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (bus.mul_valid_i) begin
                        state_q <= ST_IDLE;
                    end else if (wdog_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_hs || flush_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mgt_01_mul_arbiter.sv
// Directed bench for the shared multiplier arbiter: a 17-cycle multiplier model,
// expected products queued at accept and popped when a response appears.
module tb_mgt_01_mul_arbiter;
    localparam int XLEN = 32;

    typedef struct {
        logic            port;
        logic [XLEN-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic err;
    logic m_hang = 1'b0;
    logic [4:0] m_cnt;
    logic [XLEN-1:0] m_prod;
    int errors = 0;
    int checks = 0;
    exp_t sbq[$];

    mgt_01_mul_arbiter_if #(.XLEN(XLEN)) bus ();

    mgt_01_mul_arbiter #(.XLEN(XLEN), .TIMEOUT(20)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .flush_i(flush),
        .bus    (bus),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    // Multiplier: loads on an enabled edge while idle, counts 1..16, then reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 5'd0;
            m_prod <= '0;
        end else if (bus.mul_clk_en_o) begin
            if (m_cnt == 5'd0) begin
                m_prod <= bus.mul_multiplier_o * bus.mul_multiplicand_o;
                m_cnt  <= 5'd1;
            end else if (m_cnt == 5'd16) begin
                m_cnt <= m_hang ? 5'd16 : 5'd0;
            end else begin
                m_cnt <= m_cnt + 5'd1;
            end
        end
    end
    assign bus.mul_valid_i  = (m_cnt == 5'd0);
    assign bus.mul_result_i = m_prod;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=no event expected=event within budget", tag);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        exp_t e;
        while (!(bus.resp0_valid_o || bus.resp1_valid_o) && n < 40) begin
            tick();
            n++;
        end
        if (!(bus.resp0_valid_o || bus.resp1_valid_o)) begin
            fail({tag, " resp timeout"});
        end else if (sbq.size() == 0) begin
            fail({tag, " unexpected resp"});
        end else begin
            e = sbq.pop_front();
            check({tag, " port"}, 32'(bus.resp1_valid_o), 32'(e.port));
            check({tag, " one valid"}, 32'(bus.resp0_valid_o & bus.resp1_valid_o), 0);
            check({tag, " result"}, bus.resp_result_o, e.val);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.req0_ready_o, bus.req1_ready_o, bus.resp0_valid_o,
                bus.resp1_valid_o, bus.mul_clk_en_o, err};
    endfunction

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bad;
        bus.req0_valid_i = 0; bus.req0_multiplier_i = 0; bus.req0_multiplicand_i = 0;
        bus.req1_valid_i = 0; bus.req1_multiplier_i = 0; bus.req1_multiplicand_i = 0;
        bus.resp0_ready_i = 1; bus.resp1_ready_i = 1;

        // Reset state
        tick();
        tick();
        check("reset outputs", 32'(outs()), 0);
        check("reset result", bus.resp_result_o, 0);
        rst_n = 1'b1;
        tick();

        // Contention with ptr=0: port 0 first, port 1 after one IDLE cycle
        bus.req0_valid_i = 1; bus.req0_multiplier_i = 32'hFFFF_FFFD; bus.req0_multiplicand_i = 32'd5;
        bus.req1_valid_i = 1; bus.req1_multiplier_i = 32'd2; bus.req1_multiplicand_i = 32'h8000_0000;
        #1;
        check("cont ready0", 32'(bus.req0_ready_o), 1);
        check("cont ready1", 32'(bus.req1_ready_o), 0);
        check("cont operand", bus.mul_multiplier_o, 32'hFFFF_FFFD);
        sbq.push_back('{1'b0, 32'hFFFF_FFF1});
        tick();
        bus.req0_valid_i = 0;
        #1;
        check("cont busy ready1", 32'(bus.req1_ready_o), 0);
        check("cont idle operand", bus.mul_multiplicand_o, 0);
        wait_resp("cont0");
        tick();
        check("cont ready1 after hs", 32'(bus.req1_ready_o), 1);
        sbq.push_back('{1'b1, 32'h0000_0000});
        tick();
        bus.req1_valid_i = 0;
        wait_resp("cont1");

        // Single op with exact enable/response timing
        tick();
        tick();
        bus.req0_valid_i = 1; bus.req0_multiplier_i = 32'd7; bus.req0_multiplicand_i = 32'd6;
        #1;
        check("single ready0", 32'(bus.req0_ready_o), 1);
        check("single clk_en T", 32'(bus.mul_clk_en_o), 1);
        sbq.push_back('{1'b0, 32'd42});
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) bus.req0_valid_i = 0;
            if (bus.mul_clk_en_o !== 1'b1) bad++;
        end
        check("single clk_en T+1..16 misses", bad, 0);
        tick();
        check("single clk_en T+17", 32'(bus.mul_clk_en_o), 0);
        check("single resp0 T+17", 32'(bus.resp0_valid_o), 0);
        tick();
        check("single resp0 T+18", 32'(bus.resp0_valid_o), 1);
        check("single resp1 T+18", 32'(bus.resp1_valid_o), 0);
        wait_resp("single");

        // Backpressure on port 1 with port 0 waiting
        bus.resp1_ready_i = 0;
        tick();
        tick();
        bus.req1_valid_i = 1; bus.req1_multiplier_i = 32'd5; bus.req1_multiplicand_i = 32'd9;
        #1;
        check("bp ready1", 32'(bus.req1_ready_o), 1);
        sbq.push_back('{1'b1, 32'd45});
        tick();
        bus.req1_valid_i = 0;
        wait_resp("bp");
        bus.req0_valid_i = 1; bus.req0_multiplier_i = 32'd3; bus.req0_multiplicand_i = 32'd4;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.resp1_valid_o !== 1'b1 || bus.resp_result_o !== 32'd45 ||
                bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) bad++;
        end
        check("bp hold violations", bad, 0);
        bus.resp1_ready_i = 1;
        bus.req0_valid_i = 0;
        tick();
        check("bp resp1 after hs", 32'(bus.resp1_valid_o), 0);

        // Flush in IDLE blocks the accept, then flush mid-BUSY drains
        tick();
        bus.req0_valid_i = 1;
        flush = 1;
        #1;
        check("flush idle ready0", 32'(bus.req0_ready_o), 0);
        check("flush idle clk_en", 32'(bus.mul_clk_en_o), 0);
        tick();
        flush = 0;
        #1;
        check("flush op ready0", 32'(bus.req0_ready_o), 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) bus.req0_valid_i = 0;
        end
        flush = 1;
        tick();
        flush = 0;
        bad = 0;
        for (int i = 6; i <= 16; i++) begin
            if (i > 6) tick();
            if (bus.mul_clk_en_o !== 1'b1 || bus.resp0_valid_o || bus.resp1_valid_o) bad++;
        end
        check("drain T+6..16 violations", bad, 0);
        tick();
        check("drain clk_en T+17", 32'(bus.mul_clk_en_o), 0);
        bus.req1_valid_i = 1; bus.req1_multiplier_i = 32'd123; bus.req1_multiplicand_i = 32'hFFFF_FFFC;
        #1;
        check("drain ready1 T+17", 32'(bus.req1_ready_o), 0);
        tick();
        check("drain resp T+18", 32'({bus.resp0_valid_o, bus.resp1_valid_o}), 0);
        check("post flush ready1", 32'(bus.req1_ready_o), 1);
        sbq.push_back('{1'b1, 32'(32'd123 * 32'hFFFF_FFFC)});
        tick();
        bus.req1_valid_i = 0;
        wait_resp("post flush");

        // Asynchronous reset mid-BUSY with ptr moved to 1
        tick();
        tick();
        bus.req0_valid_i = 1; bus.req0_multiplier_i = 32'd10; bus.req0_multiplicand_i = 32'd10;
        #1;
        check("areset op ready0", 32'(bus.req0_ready_o), 1);
        tick();
        bus.req0_valid_i = 0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("areset outputs", 32'(outs()), 0);
        check("areset result", bus.resp_result_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.req0_valid_i = 1; bus.req0_multiplier_i = 32'd11; bus.req0_multiplicand_i = 32'd13;
        bus.req1_valid_i = 1; bus.req1_multiplier_i = 32'd7; bus.req1_multiplicand_i = 32'd7;
        #1;
        check("areset ptr ready0", 32'(bus.req0_ready_o), 1);
        check("areset ptr ready1", 32'(bus.req1_ready_o), 0);
        sbq.push_back('{1'b0, 32'd143});
        tick();
        bus.req0_valid_i = 0;
        bus.req1_valid_i = 0;
        wait_resp("post areset");

        // Watchdog: multiplier never finishes
        m_hang = 1'b1;
        tick();
        tick();
        bus.req1_valid_i = 1; bus.req1_multiplier_i = 32'd1; bus.req1_multiplicand_i = 32'd2;
        #1;
        check("wd ready1", 32'(bus.req1_ready_o), 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) bus.req1_valid_i = 0;
        end
        check("wd err T+20", 32'(err), 0);
        tick();
        check("wd err T+21", 32'(err), 1);
        bus.req0_valid_i = 1;
        bus.req1_valid_i = 1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (outs() !== 6'b000001) bad++;
        end
        check("wd err quiet violations", bad, 0);
        rst_n = 1'b0;
        #1;
        check("wd err cleared", 32'(err), 0);
        tick();
        m_hang = 1'b0;
        rst_n = 1'b1;
        bus.req0_multiplier_i = 32'd9; bus.req0_multiplicand_i = 32'd9;
        #1;
        check("wd recover ready0", 32'(bus.req0_ready_o), 1);
        sbq.push_back('{1'b0, 32'd81});
        tick();
        bus.req0_valid_i = 0;
        bus.req1_valid_i = 0;
        wait_resp("wd recover");

        check("scoreboard drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
